// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply core: FSM states, default parameters,
// and the row-major element address helper.
// No ports. Combinational helpers only, so there is no latency or backpressure.
package matmul_pkg;

    localparam int DEF_CORE_ID   = 0;
    localparam int DEF_NUM_CORES = 1;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ACC_W     = 24;
    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DIM_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_A,
        ST_FETCH_B,
        ST_MAC,
        ST_STORE,
        ST_NEXT,
        ST_DONE
    } state_t;

    // Row-major element address: base + row*row_len + col.
    // Evaluated at 32 bits; callers keep the low ADDR_W bits, which is the
    // same result as doing the whole sum modulo 2^ADDR_W (ADDR_W <= 32).
    function automatic logic [31:0] elem_addr(input logic [31:0] base,
                                              input logic [31:0] row,
                                              input logic [31:0] row_len,
                                              input logic [31:0] col);
        return base + row * row_len + col;
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// Multiply-accumulate register: acc <= acc + a*b, wrapping at ACC_W bits.
// Latency 1 cycle from i_en to o_acc. No backpressure: i_clr beats i_en.
// Ports: clock, rst_r (sync, active-high), i_clr, i_en, i_a, i_b, o_acc.
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clock,
    input  logic              rst_r,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [ACC_W-1:0]  o_acc
);

    logic [ACC_W-1:0]    r_acc;
    logic [2*DATA_W-1:0] w_prod;

    assign w_prod = (2*DATA_W)'(i_a) * (2*DATA_W)'(i_b);
    assign o_acc  = r_acc;

    // The product is resized to ACC_W before the add, so the sum wraps
    // modulo 2^ACC_W whether ACC_W is wider or narrower than the product.
    always_ff @(posedge clock) begin
        if (rst_r) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + ACC_W'(w_prod);
        end
    end

endmodule

// File: rtl/matmul_engine.sv
// Matrix-multiply core: computes rows i = CORE_ID (mod NUM_CORES) of C = A x B.
// Latency 3*Y+2 cycles per C element with grant held high, +1 per wait cycle.
// Backpressure: mem_req and its address/data/we hold steady until mem_gnt.
// Ports: clock/rst_r, start + dims/bases, mem_* request/grant port, busy/done/error.
module matmul_engine
    import matmul_pkg::*;
#(
    parameter int CORE_ID   = DEF_CORE_ID,
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DIM_W     = DEF_DIM_W
) (
    input  logic              clock,
    input  logic              rst_r,
    input  logic              start,
    input  logic [DIM_W-1:0]  dim_x,
    input  logic [DIM_W-1:0]  dim_y,
    input  logic [DIM_W-1:0]  dim_z,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_c,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ACC_W-1:0]  mem_wdata,
    input  logic              mem_gnt,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              error
);

    state_t            r_state;
    logic [DIM_W-1:0]  r_x, r_y, r_z;
    logic [ADDR_W-1:0] r_base_a, r_base_b, r_base_c;
    // One extra bit so the row index can step past X without wrapping.
    logic [DIM_W:0]    r_i;
    logic [DIM_W-1:0]  r_j, r_k;
    logic [DATA_W-1:0] r_a, r_b;
    logic              r_err;

    logic              w_zero_dim;
    logic              w_no_row;
    logic [31:0]       w_i_nxt;
    logic              w_mac_clr;
    logic              w_mac_en;
    logic [ACC_W-1:0]  w_acc;

    assign w_zero_dim = (dim_x == '0) || (dim_y == '0) || (dim_z == '0);
    assign w_no_row   = 32'(CORE_ID) >= 32'(dim_x);
    assign w_i_nxt    = 32'(r_i) + 32'(NUM_CORES);
    assign w_mac_clr  = ((r_state == ST_IDLE) && start) || (r_state == ST_NEXT);
    assign w_mac_en   = (r_state == ST_MAC);

    matmul_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clock  (clock),
        .rst_r  (rst_r),
        .i_clr  (w_mac_clr),
        .i_en   (w_mac_en),
        .i_a    (r_a),
        .i_b    (r_b),
        .o_acc  (w_acc)
    );

    always_ff @(posedge clock) begin
        if (rst_r) begin
            r_state  <= ST_IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_z      <= '0;
            r_base_a <= '0;
            r_base_b <= '0;
            r_base_c <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_x      <= dim_x;
                        r_y      <= dim_y;
                        r_z      <= dim_z;
                        r_base_a <= base_a;
                        r_base_b <= base_b;
                        r_base_c <= base_c;
                        r_i      <= (DIM_W+1)'(CORE_ID);
                        r_j      <= '0;
                        r_k      <= '0;
                        r_err    <= w_zero_dim;
                        r_state  <= (w_zero_dim || w_no_row) ? ST_DONE : ST_FETCH_A;
                    end
                end
                ST_FETCH_A: begin
                    if (mem_gnt) begin
                        r_a     <= mem_rdata;
                        r_state <= ST_FETCH_B;
                    end
                end
                ST_FETCH_B: begin
                    if (mem_gnt) begin
                        r_b     <= mem_rdata;
                        r_state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (r_k == r_y - DIM_W'(1)) begin
                        r_state <= ST_STORE;
                    end else begin
                        r_k     <= r_k + DIM_W'(1);
                        r_state <= ST_FETCH_A;
                    end
                end
                ST_STORE: begin
                    if (mem_gnt) begin
                        r_state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    r_k <= '0;
                    if (r_j < r_z - DIM_W'(1)) begin
                        r_j     <= r_j + DIM_W'(1);
                        r_state <= ST_FETCH_A;
                    end else begin
                        r_j     <= '0;
                        r_i     <= (DIM_W+1)'(w_i_nxt);
                        r_state <= (w_i_nxt >= 32'(r_x)) ? ST_DONE : ST_FETCH_A;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Address is decoded purely from registered state and counters, so it
    // cannot move while a request waits for its grant.
    always_comb begin
        mem_addr = '0;
        case (r_state)
            ST_FETCH_A: mem_addr = ADDR_W'(elem_addr(32'(r_base_a), 32'(r_i), 32'(r_y), 32'(r_k)));
            ST_FETCH_B: mem_addr = ADDR_W'(elem_addr(32'(r_base_b), 32'(r_k), 32'(r_z), 32'(r_j)));
            ST_STORE:   mem_addr = ADDR_W'(elem_addr(32'(r_base_c), 32'(r_i), 32'(r_z), 32'(r_j)));
            default:    mem_addr = '0;
        endcase
    end

    assign mem_req   = (r_state == ST_FETCH_A) || (r_state == ST_FETCH_B) || (r_state == ST_STORE);
    assign mem_we    = (r_state == ST_STORE);
    assign mem_wdata = w_acc;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign error     = (r_state == ST_DONE) && r_err;

endmodule
